// File: rtl/serial_subtractor.sv
// Purpose : bit-serial unsigned subtractor, A - B computed LSB first through one full-adder cell (inverted B, registered carry).
// Latency : WIDTH cycles from the accepted start to the one-cycle done pulse; one operation every WIDTH+1 cycles.
// Backpres: none; start is accepted only in IDLE or DONE, and a start while busy is dropped (no queueing).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset; aborts any operation in flight
//   start      operation request, sampled only when not busy
//   a, b       minuend / subtrahend, captured on an accepted start
//   diff       (a - b) mod 2^WIDTH, valid from done until the next accepted start
//   borrow_out 1 when a < b (unsigned), valid with diff
//   busy       high while bits are being processed
//   done       one-cycle pulse when the result becomes valid
//   overflow   signed (two's-complement) overflow flag, only when SERSUB_OVERFLOW_EN is defined
//
// Build option: define SERSUB_OVERFLOW_EN to add the overflow port and its logic.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SERSUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    // One extra bit so the counter can represent WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Encoding chosen so busy and done are each a single state flop bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   sa;        // minuend shift register
    logic [WIDTH-1:0]   sb;        // subtrahend shift register
    logic [WIDTH-1:0]   diff_sr;   // result shift register, filled from the MSB
    logic               carry;     // carry of A + ~B; 1 means no borrow
    logic [CNT_W-1:0]   bit_cnt;
    logic               borrow_q;

    logic               accept;
    logic               last_bit;
    logic               nb;
    logic               s_bit;
    logic               c_nxt;

    // Start is honoured in IDLE and in the DONE cycle, never while running.
    assign accept   = start && (state != S_RUN);
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    // Full-adder cell with inverted subtrahend: A - B = A + ~B + 1.
    assign nb    = ~sb[0];
    assign s_bit = sa[0] ^ nb ^ carry;
    assign c_nxt = (sa[0] & nb) | ((sa[0] ^ nb) & carry);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Pure state decode, so busy/done come straight from flops.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa       <= '0;
            sb       <= '0;
            diff_sr  <= '0;
            carry    <= 1'b1;
            bit_cnt  <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            // diff_sr is deliberately left alone: the previous result stays
            // visible until the new bits start shifting in.
            sa      <= a;
            sb      <= b;
            carry   <= 1'b1;
            bit_cnt <= '0;
        end else if (state == S_RUN) begin
            sa      <= sa >> 1;
            sb      <= sb >> 1;
            diff_sr <= {s_bit, diff_sr[WIDTH-1:1]};
            carry   <= c_nxt;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
                // Carry out of the final bit is the inverse of the borrow.
                borrow_q <= ~c_nxt;
            end
        end
    end

    assign diff       = diff_sr;
    assign borrow_out = borrow_q;

`ifdef SERSUB_OVERFLOW_EN
    logic ovf_q;

    // On the last bit sa[0]/sb[0] hold the operand MSBs and s_bit is the
    // result MSB: overflow when the operand signs differ and the result
    // sign differs from the minuend's.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (!accept && (state == S_RUN) && last_bit) begin
            ovf_q <= (sa[0] ^ sb[0]) & (s_bit ^ sa[0]);
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose : directed self-checking bench for serial_subtractor (WIDTH=8).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpres: exercises start-while-busy drop and start held high back to back.

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;
`ifdef SERSUB_OVERFLOW_EN
    logic         overflow;
`endif

    int passed = 0;
    int total  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
`ifdef SERSUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single operation with a start pulse; checks busy for W cycles, then
    // the done cycle with the result, then that done drops and diff holds.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check($sformatf("busy[%0d] %0d-%0d", i, ta, tb_v), 32'(busy), 32'd1);
            check($sformatf("nodone[%0d] %0d-%0d", i, ta, tb_v), 32'(done), 32'd0);
            tick();
        end
        check($sformatf("done %0d-%0d", ta, tb_v), 32'(done), 32'd1);
        check($sformatf("busy_at_done %0d-%0d", ta, tb_v), 32'(busy), 32'd0);
        check($sformatf("diff %0d-%0d", ta, tb_v), 32'(diff), 32'(ed));
        check($sformatf("borrow %0d-%0d", ta, tb_v), 32'(borrow_out), 32'(eb));
        tick();
        check($sformatf("done_pulse %0d-%0d", ta, tb_v), 32'(done), 32'd0);
        check($sformatf("diff_hold %0d-%0d", ta, tb_v), 32'(diff), 32'(ed));
    endtask

    initial begin
        logic [W-1:0] exp_d;
        logic         exp_b;
        logic         exp_done;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;

        // Reset state
        #12;
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SERSUB_OVERFLOW_EN
        check("rst_ovf", 32'(overflow), 32'd0);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // Basic vectors
        run_op(8'd200, 8'd55, 8'd145, 1'b0);
        run_op(8'd5, 8'd9, 8'hFC, 1'b1);
        run_op(8'd0, 8'd0, 8'd0, 1'b0);
        run_op(8'hFF, 8'hFF, 8'd0, 1'b0);

        // Start while running is ignored
        a     = 8'd10;
        b     = 8'd3;
        start = 1'b1;
        tick();                       // k = 0
        start = 1'b0;
        for (int k = 1; k <= W; k++) begin
            tick();
            if (k == 3) begin
                a     = 8'd99;
                b     = 8'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k < W) begin
                check($sformatf("ign_busy[%0d]", k), 32'(busy), 32'd1);
            end
        end
        check("ign_done", 32'(done), 32'd1);
        check("ign_diff", 32'(diff), 32'd7);
        check("ign_borrow", 32'(borrow_out), 32'd0);
        a = 8'd1;
        b = 8'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("idle_hold[%0d]", k), 32'(diff), 32'd7);
            check($sformatf("idle_nodone[%0d]", k), 32'(done), 32'd0);
            check($sformatf("idle_busy[%0d]", k), 32'(busy), 32'd0);
        end

        // Start held high: three back-to-back operations
        a     = 8'd30;
        b     = 8'd10;
        start = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            tick();
            if (k == 0) begin
                a = 8'd50;
                b = 8'd60;
            end else if (k == 9) begin
                a = 8'd7;
                b = 8'd7;
            end else if (k == 18) begin
                start = 1'b0;
            end
            exp_done = (k == 8) || (k == 17) || (k == 26);
            check($sformatf("b2b_done[%0d]", k), 32'(done), 32'(exp_done));
            check($sformatf("b2b_busy[%0d]", k), 32'(busy), 32'(!exp_done));
            if (exp_done) begin
                exp_d = (k == 8) ? 8'd20 : (k == 17) ? 8'd246 : 8'd0;
                exp_b = (k == 17);
                check($sformatf("b2b_diff[%0d]", k), 32'(diff), 32'(exp_d));
                check($sformatf("b2b_borrow[%0d]", k), 32'(borrow_out), 32'(exp_b));
            end
        end
        tick();

        // Leave a nonzero result so the reset check below is meaningful
        run_op(8'd3, 8'd4, 8'hFF, 1'b1);

        // Reset in the middle of an operation
        a     = 8'd100;
        b     = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_borrow", 32'(borrow_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
`ifdef SERSUB_OVERFLOW_EN
        check("mid_rst_ovf", 32'(overflow), 32'd0);
`endif
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("post_rst_nodone[%0d]", k), 32'(done), 32'd0);
        end
        run_op(8'd100, 8'd1, 8'd99, 1'b0);

`ifdef SERSUB_OVERFLOW_EN
        run_op(8'h80, 8'h01, 8'h7F, 1'b0);
        check("ovf_80_01", 32'(overflow), 32'd1);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0);
        check("ovf_10_01", 32'(overflow), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
